// File: rtl/regfile_arb_pkg.sv
// Shared types for the register file arbiter: FSM states, grant encoding, widths, latched op payload.
package regfile_arb_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } state_e;

    typedef enum logic {
        GNT_WR,
        GNT_RD
    } grant_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic [ADDR_W-1:0] rd_addr_a;
        logic [ADDR_W-1:0] rd_addr_b;
    } rf_op_t;

endpackage

// File: rtl/regfile_arb_picker.sv
// Combinational winner select between the write and read requesters.
// REGFILE_ARB_ROUND_ROBIN_EN selects pointer-based conflict resolution; otherwise write always wins.
module regfile_arb_picker
    import regfile_arb_pkg::*;
(
    input  logic   i_wr_req,
    input  logic   i_rd_req,
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    input  grant_e i_ptr,
`endif
    output grant_e o_gnt_c
);

    always_comb begin
        o_gnt_c = GNT_WR;
        if (i_wr_req && i_rd_req) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            o_gnt_c = i_ptr;
`else
            o_gnt_c = GNT_WR;
`endif
        end else if (i_rd_req) begin
            o_gnt_c = GNT_RD;
        end
    end

endmodule

// File: rtl/register_file_arbiter.sv
// Arbitrates writeback vs decode access to the register file and sequences its available/busy handshake.
// Optional macro REGFILE_ARB_ROUND_ROBIN_EN: round-robin conflict resolution instead of write priority.
module register_file_arbiter
    import regfile_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rf_available,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_addr_a,
    output logic [ADDR_W-1:0] rf_read_addr_b,
    input  logic [DATA_W-1:0] rf_read_data_a,
    input  logic [DATA_W-1:0] rf_read_data_b,
    input  logic              rf_busy
);

    state_e            r_state;
    state_e            w_state_nxt;
    rf_op_t            r_op;
    logic              r_rf_available;
    logic              r_wr_ack;
    logic              r_rd_ack;
    logic [DATA_W-1:0] r_rd_data_a;
    logic [DATA_W-1:0] r_rd_data_b;
    grant_e            w_gnt;
    logic              w_load;
    logic              w_capture;
    logic              w_avail_nxt;
    logic              w_wr_ack_nxt;
    logic              w_rd_ack_nxt;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    grant_e r_ptr;

    // Pointer moves only on grants made while both ports were requesting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= GNT_WR;
        end else if (w_load && wr_req && rd_req) begin
            r_ptr <= (w_gnt == GNT_WR) ? GNT_RD : GNT_WR;
        end
    end
`endif

    regfile_arb_picker u_picker (
        .i_wr_req (wr_req),
        .i_rd_req (rd_req),
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        .i_ptr    (r_ptr),
`endif
        .o_gnt_c  (w_gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the next values of the registered handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_avail_nxt  = 1'b0;
        w_wr_ack_nxt = 1'b0;
        w_rd_ack_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr_req || rd_req) begin
                    w_state_nxt = ISSUE;
                    w_load      = 1'b1;
                    w_avail_nxt = 1'b1;
                end
            end
            ISSUE: begin
                w_avail_nxt = 1'b1;
                if (rf_busy) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_avail_nxt = 1'b1;
                if (!rf_busy) begin
                    w_state_nxt  = RELEASE;
                    w_avail_nxt  = 1'b0;
                    w_wr_ack_nxt = r_op.we;
                    w_rd_ack_nxt = !r_op.we;
                    w_capture    = !r_op.we;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch on grant, read-data capture on read completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op           <= '0;
            r_rf_available <= 1'b0;
            r_wr_ack       <= 1'b0;
            r_rd_ack       <= 1'b0;
            r_rd_data_a    <= '0;
            r_rd_data_b    <= '0;
        end else begin
            r_rf_available <= w_avail_nxt;
            r_wr_ack       <= w_wr_ack_nxt;
            r_rd_ack       <= w_rd_ack_nxt;
            if (w_load) begin
                r_op.we <= (w_gnt == GNT_WR);
                if (w_gnt == GNT_WR) begin
                    r_op.wr_addr <= wr_addr;
                    r_op.wr_data <= wr_data;
                end else begin
                    r_op.rd_addr_a <= rd_addr_a;
                    r_op.rd_addr_b <= rd_addr_b;
                end
            end
            if (w_capture) begin
                r_rd_data_a <= rf_read_data_a;
                r_rd_data_b <= rf_read_data_b;
            end
        end
    end

    assign rf_available   = r_rf_available;
    assign rf_write_en    = r_op.we;
    assign rf_write_addr  = r_op.wr_addr;
    assign rf_write_data  = r_op.wr_data;
    assign rf_read_addr_a = r_op.rd_addr_a;
    assign rf_read_addr_b = r_op.rd_addr_b;
    assign wr_ack         = r_wr_ack;
    assign rd_ack         = r_rd_ack;
    assign rd_data_a      = r_rd_data_a;
    assign rd_data_b      = r_rd_data_b;

endmodule

// File: tb/tb_register_file_arbiter.sv
// Self-checking bench for register_file_arbiter with a behavioural register file and expected-memory model.
// Honours REGFILE_ARB_ROUND_ROBIN_EN when computing the expected conflict grant order.
module tb_register_file_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        rd_ack;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rf_available;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [3:0]  rf_read_addr_a;
    logic [3:0]  rf_read_addr_b;
    logic [31:0] rf_read_data_a;
    logic [31:0] rf_read_data_b;
    logic        rf_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Register file stand-in: busy one cycle for a write, two for a read, re-arms once available drops.
    logic [31:0] rf_mem [16] = '{default: 32'h0};
    int          m_phase;
    int          m_cnt;

    // What the register file should hold, driven only by what the bench asked for.
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;

    always #5 clk = ~clk;

    register_file_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .rd_req         (rd_req),
        .rd_addr_a      (rd_addr_a),
        .rd_addr_b      (rd_addr_b),
        .rd_ack         (rd_ack),
        .rd_data_a      (rd_data_a),
        .rd_data_b      (rd_data_b),
        .rf_available   (rf_available),
        .rf_write_en    (rf_write_en),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_read_addr_a (rf_read_addr_a),
        .rf_read_addr_b (rf_read_addr_b),
        .rf_read_data_a (rf_read_data_a),
        .rf_read_data_b (rf_read_data_b),
        .rf_busy        (rf_busy)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_busy        <= 1'b0;
            m_phase        <= 0;
            m_cnt          <= 0;
            rf_read_data_a <= 32'h0;
            rf_read_data_b <= 32'h0;
        end else begin
            case (m_phase)
                0: if (rf_available) begin
                    rf_busy <= 1'b1;
                    m_phase <= 1;
                    if (rf_write_en) begin
                        m_cnt <= 1;
                        if (rf_write_addr != 4'd0) rf_mem[rf_write_addr] <= rf_write_data;
                    end else begin
                        m_cnt          <= 2;
                        rf_read_data_a <= rf_mem[rf_read_addr_a];
                        rf_read_data_b <= rf_mem[rf_read_addr_b];
                    end
                end
                1: begin
                    if (m_cnt == 1) begin
                        rf_busy <= 1'b0;
                        m_phase <= 2;
                    end
                    m_cnt <= m_cnt - 1;
                end
                default: if (!rf_available) m_phase <= 0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete operation started from IDLE; a write commits 4 cycles after req, a read acks after 5.
    task automatic run_op(input bit is_wr, input bit drop_early, input logic [3:0] a0,
                          input logic [3:0] a1, input logic [31:0] d);
        int          lat;
        logic [31:0] ea;
        logic [31:0] eb;
        lat = is_wr ? 4 : 5;
        ea  = ref_mem[a0];
        eb  = ref_mem[a1];
        @(negedge clk);
        if (is_wr) begin
            wr_req = 1'b1; wr_addr = a0; wr_data = d;
        end else begin
            rd_req = 1'b1; rd_addr_a = a0; rd_addr_b = a1;
        end
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            if (drop_early && cyc == 1) begin
                wr_req = 1'b0; wr_addr = a0 ^ 4'hF; wr_data = ~d;
            end
            check("rf_available", 32'(rf_available), 32'(cyc < lat));
            check("op_ack", 32'(is_wr ? wr_ack : rd_ack), 32'(cyc == lat));
            if (cyc == lat - 1) begin
                check("rf_write_en", 32'(rf_write_en), 32'(is_wr));
                if (is_wr) begin
                    check("rf_write_addr", 32'(rf_write_addr), 32'(a0));
                    check("rf_write_data", rf_write_data, d);
                end else begin
                    check("rf_read_addr_a", 32'(rf_read_addr_a), 32'(a0));
                    check("rf_read_addr_b", 32'(rf_read_addr_b), 32'(a1));
                end
            end
        end
        check("other_ack", 32'(is_wr ? rd_ack : wr_ack), 32'd0);
        if (is_wr) begin
            wr_req = 1'b0;
            if (a0 != 4'd0) ref_mem[a0] = d;
            check("rd_data_a_hold", rd_data_a, last_a);
            check("rd_data_b_hold", rd_data_b, last_b);
        end else begin
            rd_req = 1'b0;
            check("rd_data_a", rd_data_a, ea);
            check("rd_data_b", rd_data_b, eb);
            last_a = ea;
            last_b = eb;
        end
    endtask

    // Both requesters held high for four grants; expected order follows the arbitration rule.
    task automatic run_conflict();
        int n;
        bit exp_wr;
        n = 0;
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 4'd12; wr_data = 32'hC0FFEE01;
        rd_req = 1'b1; rd_addr_a = 4'd12; rd_addr_b = 4'd5;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            if (wr_ack || rd_ack) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
                exp_wr = (n % 2 == 0);
`else
                exp_wr = 1'b1;
`endif
                check("conf_wr_ack", 32'(wr_ack), 32'(exp_wr));
                check("conf_rd_ack", 32'(rd_ack), 32'(!exp_wr));
                if (wr_ack) ref_mem[12] = 32'hC0FFEE01;
                if (rd_ack) begin
                    check("conf_rd_data_a", rd_data_a, ref_mem[12]);
                    check("conf_rd_data_b", rd_data_b, ref_mem[5]);
                    last_a = ref_mem[12];
                    last_b = ref_mem[5];
                end
                n++;
                if (n == 4) begin
                    wr_req = 1'b0;
                    rd_req = 1'b0;
                end
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        check("conf_ops", 32'(n), 32'd4);
    endtask

    initial begin
        reset_n = 1'b0;
        wr_req = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
        rd_req = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_rf_available", 32'(rf_available), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_rd_ack", 32'(rd_ack), 32'd0);
        check("rst_rf_write_en", 32'(rf_write_en), 32'd0);
        check("rst_rf_write_addr", 32'(rf_write_addr), 32'd0);
        check("rst_rf_write_data", rf_write_data, 32'd0);
        check("rst_rf_read_addr_a", 32'(rf_read_addr_a), 32'd0);
        check("rst_rd_data_a", rd_data_a, 32'd0);
        check("rst_rd_data_b", rd_data_b, 32'd0);
        reset_n = 1'b1;

        run_op(1'b1, 1'b0, 4'd5, 4'd0, 32'hDEADBEEF);
        run_op(1'b0, 1'b0, 4'd5, 4'd0, 32'h0);
        run_op(1'b1, 1'b0, 4'd3, 4'd0, 32'h11);
        run_op(1'b1, 1'b0, 4'd7, 4'd0, 32'h22);
        run_op(1'b0, 1'b0, 4'd3, 4'd7, 32'h0);
        run_op(1'b1, 1'b0, 4'd9, 4'd0, 32'h5A5A5A5A);
        run_op(1'b1, 1'b0, 4'd0, 4'd0, 32'hFFFFFFFF);
        run_op(1'b0, 1'b0, 4'd0, 4'd0, 32'h0);

        // Write request withdrawn while the op is in flight.
        run_op(1'b1, 1'b1, 4'd10, 4'd0, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_extra_ack", 32'(wr_ack), 32'd0);
        end
        run_op(1'b0, 1'b0, 4'd10, 4'd5, 32'h0);

        // Reset while a read is waiting on busy.
        run_op(1'b0, 1'b0, 4'd3, 4'd7, 32'h0);
        @(negedge clk);
        rd_req = 1'b1; rd_addr_a = 4'd9; rd_addr_b = 4'd10;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(rf_busy), 32'd1);
        reset_n = 1'b0;
        rd_req  = 1'b0;
        #1;
        check("mid_rst_available", 32'(rf_available), 32'd0);
        check("mid_rst_rd_ack", 32'(rd_ack), 32'd0);
        check("mid_rst_rd_data_a", rd_data_a, 32'd0);
        check("mid_rst_rd_data_b", rd_data_b, 32'd0);
        @(negedge clk);
        check("mid_rst_rd_ack_held", 32'(rd_ack), 32'd0);
        reset_n = 1'b1;
        last_a = 32'h0;
        last_b = 32'h0;
        run_op(1'b0, 1'b0, 4'd9, 4'd10, 32'h0);

        run_conflict();
        @(negedge clk);

        for (int k = 0; k < 24; k++) begin
            run_op(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
